// File: rtl/dm_store_buffer_pkg.sv
// Shared types and default sizing for the data-memory store buffer.
// The entry struct is sized by the package defaults.
package dm_store_buffer_pkg;

    localparam int SB_DEPTH  = 4;
    localparam int SB_ADDR_W = 6;
    localparam int SB_DATA_W = 32;
    localparam int SB_PTR_W  = $clog2(SB_DEPTH);

    typedef struct packed {
        logic [SB_ADDR_W-1:0] addr;
        logic [SB_DATA_W-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/sb_fwd_match.sv
// Store-to-load forwarding selector: returns the youngest pending entry whose
// address matches the load probe. Purely combinational.
module sb_fwd_match
    import dm_store_buffer_pkg::*;
#(
    parameter int DEPTH  = SB_DEPTH,
    parameter int ADDR_W = SB_ADDR_W,
    parameter int DATA_W = SB_DATA_W
) (
    input  sb_entry_t                  entries [DEPTH],
    input  logic [$clog2(DEPTH)-1:0]   head,
    input  logic [$clog2(DEPTH):0]     count,
    input  logic [ADDR_W-1:0]          ld_addr,
    output logic                       ld_hit,
    output logic [DATA_W-1:0]          ld_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] idx;

    // Walk oldest to youngest so a later match overwrites an earlier one.
    always_comb begin
        ld_hit  = 1'b0;
        ld_data = '0;
        idx     = head;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if ((CNT_W'(i) < count) && (entries[idx].addr == ld_addr)) begin
                ld_hit  = 1'b1;
                ld_data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/dm_store_buffer.sv
// Posted-write buffer between the core memory stage and data memory:
// in-order FIFO drain with youngest-match store-to-load forwarding.
module dm_store_buffer
    import dm_store_buffer_pkg::*;
#(
    parameter int DEPTH  = SB_DEPTH,
    parameter int ADDR_W = SB_ADDR_W,
    parameter int DATA_W = SB_DATA_W
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       st_valid,
    input  logic [ADDR_W-1:0]          st_addr,
    input  logic [DATA_W-1:0]          st_data,
    output logic                       st_ready,
    input  logic [ADDR_W-1:0]          ld_addr,
    output logic                       ld_hit,
    output logic [DATA_W-1:0]          ld_data,
    output logic                       mem_we,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    input  logic                       mem_ack,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    sb_entry_t        entries [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             push;
    logic             pop;

    // Handshakes: a store transfers on an edge where st_valid && st_ready;
    // a memory write retires on an edge where mem_we && mem_ack. Both ready
    // and mem_we come from registered count only, so a full buffer does not
    // accept a store even if it drains on the same edge.
    assign st_ready  = (count != CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign mem_we    = !empty;
    assign mem_addr  = entries[head].addr;
    assign mem_wdata = entries[head].data;
    assign push      = st_valid && st_ready;
    assign pop       = mem_we && mem_ack;

    // Entry payload needs no reset; occupancy is carried by count.
    always_ff @(posedge clock) begin
        if (push) begin
            entries[tail] <= '{addr: st_addr, data: st_data};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PTR_W'(1);
            if (pop)  head <= head + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    sb_fwd_match #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fwd (
        .entries (entries),
        .head    (head),
        .count   (count),
        .ld_addr (ld_addr),
        .ld_hit  (ld_hit),
        .ld_data (ld_data)
    );

endmodule
